mux_display_scanner: RTL and testbench

MUX_DISPLAY_SCANNER -- requirements
Module: mux_display_scanner

---
 rtl/mux_display_pkg.sv | 25 ++
 rtl/hex_to_7seg.sv | 30 +++
 rtl/mux_display_scanner.sv | 160 ++++++++++++++++
 tb/tb_mux_display_scanner.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_display_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// Segment and anode encodings are active-low throughout.
package mux_display_pkg;

  localparam int unsigned DIGITS    = 4;
  localparam logic [6:0]  SEG_OFF   = 7'h7F;
  localparam logic [3:0]  ANODE_OFF = 4'hF;

  typedef enum logic [1:0] {
    StOff   = 2'd0,
    StDrive = 2'd1,
    StBlank = 2'd2
  } scan_state_e;

  // Active-low one-cold anode pattern for a digit, or all dark when blanked.
  function automatic logic [3:0] anode_select(input logic [1:0] idx, input logic dark);
    logic [3:0] pattern;
    pattern = ANODE_OFF;
    if (!dark) begin
      pattern[idx] = 1'b0;
    end
    return pattern;
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble to active-low seven-segment decoder, output ordered g..a.
module hex_to_7seg (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    unique case (nibble_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/mux_display_scanner.sv
// Four-digit multiplexed display scanner with inter-digit blanking and a
// double-buffered value/dp/blank update that only lands on frame boundaries.
module mux_display_scanner
  import mux_display_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic        clock_in,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        scan_tick,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  input  logic        load_valid,
  output logic        load_ready,
  output logic [3:0]  anode_out,
  output logic [6:0]  segment_out,
  output logic        dp_out,
  output logic        frame_done
);

  localparam logic [7:0] BlankLoad = 8'(BLANK_CYCLES - 1);

  scan_state_e state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [15:0] disp_value_q, disp_value_d;
  logic [3:0]  disp_dp_q, disp_dp_d;
  logic [3:0]  disp_blank_q, disp_blank_d;

  logic [15:0] pend_value_q;
  logic [3:0]  pend_dp_q;
  logic [3:0]  pend_blank_q;
  logic        load_ready_q;

  logic [3:0]  anode_q;
  logic [6:0]  segment_q;
  logic        dp_q;
  logic        frame_done_q;

  logic        frame_end;
  logic        capture;
  logic        commit;
  logic [3:0]  nibble_next;
  logic [6:0]  seg_next;

  assign load_ready  = load_ready_q;
  assign anode_out   = anode_q;
  assign segment_out = segment_q;
  assign dp_out      = dp_q;
  assign frame_done  = frame_done_q;

  // load_ready low means the pending buffer holds an uncommitted update.
  assign capture   = load_valid && load_ready_q;
  assign frame_end = enable && (state_q == StBlank) && (cnt_q == 8'd0) && (idx_q == 2'd3);
  assign commit    = !load_ready_q && ((state_q == StOff) || frame_end);

  always_comb begin
    disp_value_d = disp_value_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    if (commit) begin
      disp_value_d = pend_value_q;
      disp_dp_d    = pend_dp_q;
      disp_blank_d = pend_blank_q;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = StOff;
      idx_d   = 2'd0;
    end else begin
      unique case (state_q)
        StOff: begin
          state_d = StDrive;
          idx_d   = 2'd0;
        end
        StDrive: begin
          if (scan_tick) begin
            state_d = StBlank;
            cnt_d   = BlankLoad;
          end
        end
        StBlank: begin
          if (cnt_q == 8'd0) begin
            state_d = StDrive;
            idx_d   = idx_q + 2'd1;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: begin
          state_d = StOff;
          idx_d   = 2'd0;
        end
      endcase
    end
  end

  // Decode from next-state values so outputs register alongside the state.
  assign nibble_next = disp_value_d[{idx_d, 2'b00} +: 4];

  hex_to_7seg u_decoder (
    .nibble_i (nibble_next),
    .seg_o    (seg_next)
  );

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      state_q      <= StOff;
      idx_q        <= 2'd0;
      cnt_q        <= 8'd0;
      disp_value_q <= 16'h0000;
      disp_dp_q    <= 4'h0;
      disp_blank_q <= 4'h0;
      pend_value_q <= 16'h0000;
      pend_dp_q    <= 4'h0;
      pend_blank_q <= 4'h0;
      load_ready_q <= 1'b1;
      anode_q      <= ANODE_OFF;
      segment_q    <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      disp_value_q <= disp_value_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      frame_done_q <= frame_end;

      if (state_d == StDrive) begin
        anode_q   <= anode_select(idx_d, disp_blank_d[idx_d]);
        segment_q <= seg_next;
        dp_q      <= ~disp_dp_d[idx_d];
      end else begin
        anode_q   <= ANODE_OFF;
        segment_q <= SEG_OFF;
        dp_q      <= 1'b1;
      end

      if (capture) begin
        pend_value_q <= value_in;
        pend_dp_q    <= dp_in;
        pend_blank_q <= blank_in;
        load_ready_q <= 1'b0;
      end else if (commit) begin
        load_ready_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_display_scanner.sv
// Directed bench for mux_display_scanner with BLANK_CYCLES = 2; every expected
// value below is a hand-decoded active-low pattern.
module tb_mux_display_scanner;

  logic        clock_in = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        scan_tick;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        load_valid;
  logic        load_ready;
  logic [3:0]  anode_out;
  logic [6:0]  segment_out;
  logic        dp_out;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  mux_display_scanner #(
    .BLANK_CYCLES (2)
  ) dut (
    .clock_in    (clock_in),
    .reset_n     (reset_n),
    .enable      (enable),
    .scan_tick   (scan_tick),
    .value_in    (value_in),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .anode_out   (anode_out),
    .segment_out (segment_out),
    .dp_out      (dp_out),
    .frame_done  (frame_done)
  );

  always #5 clock_in = ~clock_in;

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] an, input logic [6:0] seg,
                           input logic dp);
    check({tag, ".anode"}, 16'(anode_out), 16'(an));
    check({tag, ".seg"}, 16'(segment_out), 16'(seg));
    check({tag, ".dp"}, 16'(dp_out), 16'(dp));
  endtask

  // One digit slot: tick, two blank cycles, next digit driven.
  task automatic slot();
    scan_tick = 1'b1;
    step();
    scan_tick = 1'b0;
    step();
    step();
  endtask

  initial begin
    reset_n    = 1'b0;
    enable     = 1'b0;
    scan_tick  = 1'b0;
    value_in   = 16'h0000;
    dp_in      = 4'h0;
    blank_in   = 4'h0;
    load_valid = 1'b0;
    step();
    step();
    check_out("reset", 4'b1111, 7'h7F, 1'b1);
    check("reset.load_ready", 16'(load_ready), 16'd1);
    check("reset.frame_done", 16'(frame_done), 16'd0);
    reset_n = 1'b1;

    // Load while OFF: captured, then committed on the following cycle.
    value_in   = 16'h1234;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    check("off_capture.load_ready", 16'(load_ready), 16'd0);
    step();
    check("off_commit.load_ready", 16'(load_ready), 16'd1);
    check_out("off_dark", 4'b1111, 7'h7F, 1'b1);

    enable = 1'b1;
    step();
    check_out("digit0_4", 4'b1110, 7'b0011001, 1'b1);
    step();
    check_out("digit0_hold", 4'b1110, 7'b0011001, 1'b1);

    // Blank lasts exactly two cycles; tick held on the 2nd edge must be ignored.
    scan_tick = 1'b1;
    step();
    check_out("blank_c1", 4'b1111, 7'h7F, 1'b1);
    step();
    scan_tick = 1'b0;
    check_out("blank_c2", 4'b1111, 7'h7F, 1'b1);
    step();
    check_out("digit1_3", 4'b1101, 7'b0110000, 1'b1);

    // Update during digit 1 waits for the frame boundary.
    value_in   = 16'hABCD;
    load_valid = 1'b1;
    step();
    check("pend.load_ready", 16'(load_ready), 16'd0);
    value_in = 16'h5555;
    step();
    check("pend_busy.load_ready", 16'(load_ready), 16'd0);
    load_valid = 1'b0;
    check_out("digit1_still_3", 4'b1101, 7'b0110000, 1'b1);
    slot();
    check_out("digit2_2", 4'b1011, 7'b0100100, 1'b1);
    slot();
    check_out("digit3_1", 4'b0111, 7'b1111001, 1'b1);
    check("digit3.frame_done", 16'(frame_done), 16'd0);
    scan_tick = 1'b1;
    step();
    scan_tick = 1'b0;
    check("blank3_c1.frame_done", 16'(frame_done), 16'd0);
    step();
    check("blank3_c2.frame_done", 16'(frame_done), 16'd0);
    step();
    check("frame_end.frame_done", 16'(frame_done), 16'd1);
    check_out("digit0_d", 4'b1110, 7'b0100001, 1'b1);
    check("commit.load_ready", 16'(load_ready), 16'd1);
    step();
    check("pulse_width.frame_done", 16'(frame_done), 16'd0);

    // Blank digit 3 and light the dp on digit 0.
    value_in   = 16'hABCD;
    dp_in      = 4'b0001;
    blank_in   = 4'b1000;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    slot();
    check_out("f2_digit1_C", 4'b1101, 7'b1000110, 1'b1);
    slot();
    check_out("f2_digit2_b", 4'b1011, 7'b0000011, 1'b1);
    slot();
    check_out("f2_digit3_A", 4'b0111, 7'b0001000, 1'b1);
    slot();
    check("f2_end.frame_done", 16'(frame_done), 16'd1);
    check_out("f3_digit0_dp", 4'b1110, 7'b0100001, 1'b0);
    slot();
    slot();
    check_out("f3_digit2", 4'b1011, 7'b0000011, 1'b1);
    slot();
    check_out("f3_digit3_blanked", 4'b1111, 7'b0001000, 1'b1);
    scan_tick = 1'b1;
    step();
    scan_tick = 1'b0;
    check_out("f3_blank3", 4'b1111, 7'h7F, 1'b1);
    step();
    step();
    check("f3_end.frame_done", 16'(frame_done), 16'd1);
    check_out("f4_digit0", 4'b1110, 7'b0100001, 1'b0);

    // Enable dropped mid-blank: OFF next cycle, restart from digit 0.
    scan_tick = 1'b1;
    step();
    scan_tick = 1'b0;
    enable    = 1'b0;
    step();
    check_out("disable_off", 4'b1111, 7'h7F, 1'b1);
    step();
    check_out("disable_stays_off", 4'b1111, 7'h7F, 1'b1);
    enable = 1'b1;
    step();
    check_out("reenable_digit0", 4'b1110, 7'b0100001, 1'b0);

    // Reset with a pending update discards it.
    value_in   = 16'h0007;
    dp_in      = 4'h0;
    blank_in   = 4'h0;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    check("pre_reset.load_ready", 16'(load_ready), 16'd0);
    reset_n = 1'b0;
    step();
    check("mid_reset.load_ready", 16'(load_ready), 16'd1);
    check_out("mid_reset", 4'b1111, 7'h7F, 1'b1);
    reset_n = 1'b1;
    step();
    check_out("post_reset_digit0_0", 4'b1110, 7'b1000000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
